// File: rtl/actel_pkg.sv
// Shared types and constants for the C2 share arbiter: FSM states, requester count,
// and the operand field layout.
package actel_pkg;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned OPW    = 8;
  localparam int unsigned IDW    = 2;
  localparam int unsigned A0_OFS = 0;
  localparam int unsigned B0_OFS = 1;
  localparam int unsigned A1_OFS = 2;
  localparam int unsigned B1_OFS = 3;
  localparam int unsigned D_OFS  = 4;
  localparam int unsigned D_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Field order matches the offsets above (d in [7:4], a0 in [0]).
  typedef struct packed {
    logic [D_W-1:0] d;
    logic           b1;
    logic           a1;
    logic           b0;
    logic           a0;
  } operand_t;

endpackage

// File: rtl/c2_eval.sv
// C2 evaluation cell: two select terms pick one bit of the 4-bit data word.
module c2_eval (
  input  logic       a0,
  input  logic       b0,
  input  logic       a1,
  input  logic       b1,
  input  logic [3:0] d,
  output logic       out
);

  logic [1:0] sel;

  assign sel = {a1 | b1, a0 & b0};
  assign out = d[sel];

endmodule

// File: rtl/c2_share_arbiter.sv
// Arbitrates NREQ requesters onto one C2 evaluation cell; one result per 3 cycles,
// round-robin or fixed-priority grant, results held under backpressure.
module c2_share_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned RR_EN = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_id,
  output logic              rsp_out,
  output logic              busy
);

  import actel_pkg::*;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  lat_id;
  operand_t        lat_op;
  logic [IDW-1:0]  winner;
  logic            any_req;
  logic            eval_out;

  // First set bit scanning upward from start, wrapping modulo NREQ.
  function automatic logic [IDW-1:0] pick(input logic [NREQ-1:0] v,
                                          input logic [IDW-1:0]  start);
    logic [IDW-1:0] idx;
    logic           found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = start + IDW'(i);
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // Grant decode; req_ready must pulse in the accept cycle so it is decoded from state.
  always_comb begin
    req_ready = '0;
    any_req   = |req_valid;
    winner    = pick(req_valid, (RR_EN != 0) ? ptr : '0);
    if (state == ST_IDLE && any_req) begin
      req_ready[winner] = 1'b1;
    end
  end

  c2_eval u_eval (
    .a0  (lat_op.a0),
    .b0  (lat_op.b0),
    .a1  (lat_op.a1),
    .b1  (lat_op.b1),
    .d   (lat_op.d),
    .out (eval_out)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      lat_id    <= '0;
      lat_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_out   <= 1'b0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            lat_op <= operand_t'(req_data[OPW*winner +: OPW]);
            lat_id <= winner;
            busy   <= 1'b1;
            state  <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          rsp_out   <= eval_out;
          rsp_id    <= lat_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
            if (RR_EN != 0) begin
              ptr <= lat_id + IDW'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c2_share_arbiter.sv
// Scoreboard bench for c2_share_arbiter: a round-robin and a fixed-priority instance
// share data and rsp_ready; monitors compare accepts and responses against queues.
module tb_c2_share_arbiter;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] req_data;
  logic        rsp_ready;
  logic [3:0]  v_rr, v_fp;

  logic [3:0]  rr_ready, fp_ready;
  logic        rr_rsp_valid, fp_rsp_valid;
  logic [1:0]  rr_rsp_id, fp_rsp_id;
  logic        rr_rsp_out, fp_rsp_out;
  logic        rr_busy, fp_busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [1:0] acc_q[$];
  logic [2:0] rsp_q[$];
  logic [1:0] fp_acc_q[$];
  logic [2:0] fp_rsp_q[$];

  int   last_acc   = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  c2_share_arbiter #(.NREQ(4), .RR_EN(1)) dut_rr (
    .clk(clk), .clr_n(clr_n), .req_valid(v_rr), .req_data(req_data),
    .req_ready(rr_ready), .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rr_rsp_id), .rsp_out(rr_rsp_out), .busy(rr_busy)
  );

  c2_share_arbiter #(.NREQ(4), .RR_EN(0)) dut_fp (
    .clk(clk), .clr_n(clr_n), .req_valid(v_fp), .req_data(req_data),
    .req_ready(fp_ready), .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(fp_rsp_id), .rsp_out(fp_rsp_out), .busy(fp_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic c2_model(input logic [7:0] v);
    logic [3:0] d;
    logic [1:0] s;
    d = v[7:4];
    s = {v[2] | v[3], v[0] & v[1]};
    return d[s];
  endfunction

  // Round-robin instance monitor: accepts, responses and accept-to-valid latency.
  always @(negedge clk) begin
    if (clr_n) begin
      if (rr_ready != 4'd0) begin
        if (acc_q.size() == 0) check("rr_unexpected_accept", 32'(rr_ready), 32'd0);
        else check("rr_accept", 32'(rr_ready), 32'd1 << acc_q.pop_front());
        last_acc <= cyc;
      end
      if (rr_rsp_valid && !prev_valid) check("rr_latency", 32'(cyc - last_acc), 32'd2);
      if (rr_rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) check("rr_unexpected_rsp", 32'({rr_rsp_id, rr_rsp_out}), 32'hFF);
        else check("rr_rsp", 32'({rr_rsp_id, rr_rsp_out}), 32'(rsp_q.pop_front()));
      end
    end
    prev_valid <= rr_rsp_valid;
  end

  // Fixed-priority instance monitor.
  always @(negedge clk) begin
    if (clr_n) begin
      if (fp_ready != 4'd0) begin
        if (fp_acc_q.size() == 0) check("fp_unexpected_accept", 32'(fp_ready), 32'd0);
        else check("fp_accept", 32'(fp_ready), 32'd1 << fp_acc_q.pop_front());
      end
      if (fp_rsp_valid && rsp_ready) begin
        if (fp_rsp_q.size() == 0) check("fp_unexpected_rsp", 32'({fp_rsp_id, fp_rsp_out}), 32'hFF);
        else check("fp_rsp", 32'({fp_rsp_id, fp_rsp_out}), 32'(fp_rsp_q.pop_front()));
      end
    end
  end

  task automatic wait_accept(input int maxc, output int at);
    bit found = 1'b0;
    at = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (rr_ready != 4'd0 || fp_ready != 4'd0) begin
        at = cyc;
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: no accept within %0d cycles, required one", maxc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    bit found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!rr_busy && !fp_busy) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", maxc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 clr_n = 1'b0;
    @(posedge clk);
    #1 clr_n = 1'b1;
  endtask

  initial begin
    int at, prev;
    logic [7:0] op;

    clr_n = 1'b0;
    req_data = 32'd0;
    rsp_ready = 1'b0;
    v_rr = 4'd0;
    v_fp = 4'd0;
    #12;
    check("reset_rr_outputs", 32'({rr_ready, rr_rsp_valid, rr_rsp_id, rr_rsp_out, rr_busy}), 32'd0);
    check("reset_fp_outputs", 32'({fp_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_out, fp_busy}), 32'd0);
    @(posedge clk);
    #1 clr_n = 1'b1;

    // Single request: A0=B0=1, A1=B1=0, D=0010 -> out 1
    req_data[7:0] = 8'h23;
    req_data[15:8] = 8'h01;
    req_data[23:16] = 8'h4C;
    req_data[31:24] = 8'h7B;
    rsp_ready = 1'b1;
    v_rr = 4'b0001;
    acc_q.push_back(2'd0);
    rsp_q.push_back({2'd0, 1'b1});
    wait_accept(4, at);
    v_rr = 4'd0;
    wait_idle(8);

    // Round-robin with all four valid from a fresh pointer
    pulse_reset();
    foreach (acc_q[i]) acc_q.delete(i);
    acc_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rsp_q = '{{2'd0, 1'b1}, {2'd1, 1'b0}, {2'd2, 1'b1}, {2'd3, 1'b0}, {2'd0, 1'b1}};
    v_rr = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_accept(6, at);
      if (k > 0) check("rr_gap", 32'(at - prev), 32'd3);
      prev = at;
    end
    v_rr = 4'd0;
    wait_idle(8);

    // Backpressure: result held, no accepts, busy high
    rsp_ready = 1'b0;
    v_rr = 4'b0100;
    acc_q.push_back(2'd2);
    rsp_q.push_back({2'd2, 1'b1});
    wait_accept(4, at);
    v_rr = 4'b1011;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold", 32'({rr_rsp_valid, rr_rsp_id, rr_rsp_out, rr_busy}), 32'({1'b1, 2'd2, 1'b1, 1'b1}));
      check("bp_no_accept", 32'(rr_ready), 32'd0);
    end
    @(posedge clk);
    #1 v_rr = 4'd0;
    rsp_ready = 1'b1;
    wait_idle(6);

    // Reset during EVAL: in-flight result dropped, pointer back to 0
    v_rr = 4'b0010;
    acc_q.push_back(2'd1);
    wait_accept(4, at);
    v_rr = 4'd0;
    #2 clr_n = 1'b0;
    #1;
    check("clr_outputs", 32'({rr_ready, rr_rsp_valid, rr_rsp_id, rr_rsp_out, rr_busy}), 32'd0);
    @(negedge clk);
    check("clr_no_rsp", 32'(rr_rsp_valid), 32'd0);
    @(posedge clk);
    #1 clr_n = 1'b1;
    v_rr = 4'b1111;
    acc_q.push_back(2'd0);
    rsp_q.push_back({2'd0, 1'b1});
    wait_accept(1, at);
    v_rr = 4'd0;
    wait_idle(8);

    // Fixed priority: req3 starved, req0 every 3 cycles
    v_fp = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      fp_acc_q.push_back(2'd0);
      fp_rsp_q.push_back({2'd0, 1'b1});
    end
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_accept(6, at);
      if (k > 0) check("fp_gap", 32'(at - prev), 32'd3);
      prev = at;
    end
    v_fp = 4'd0;
    wait_idle(8);

    // Exhaustive operand sweep through requester 2; data scrambled after accept
    for (int v = 0; v < 256; v++) begin
      op = 8'(v);
      req_data[23:16] = op;
      v_rr = 4'b0100;
      acc_q.push_back(2'd2);
      rsp_q.push_back({2'd2, c2_model(op)});
      wait_accept(4, at);
      v_rr = 4'd0;
      req_data[23:16] = ~op;
      wait_idle(6);
    end

    for (int i = 0; i < 20; i++) begin
      if (acc_q.size() == 0 && rsp_q.size() == 0 && fp_acc_q.size() == 0 && fp_rsp_q.size() == 0) break;
      @(negedge clk);
    end
    check("rr_queues_drained", 32'(acc_q.size() + rsp_q.size()), 32'd0);
    check("fp_queues_drained", 32'(fp_acc_q.size() + fp_rsp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/c2_share_arbiter.md
C2_SHARE_ARBITER -- requirements
Module: c2_share_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one C2 evaluation cell (fixed at 4 in this revision).
REQ-002 Parameter RR_EN, default 1, 1 = round-robin grant, 0 = fixed priority (requester 0 highest).
REQ-003 clk  input  1  single clock; all state updates on the posedge.
REQ-004 clr_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  NREQ  requester i presents an operand.
REQ-006 req_data  input  8*NREQ  operand for requester i in bits [8i+7:8i], laid out as [0]=A0, [1]=B0, [2]=A1, [3]=B1, [7:4]=D[3:0].
REQ-007 req_ready  output  NREQ  one-hot; high for exactly the cycle in which requester i's operand is accepted.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_id  output  2  index of the requester that owns the result.
REQ-011 rsp_out  output  1  evaluated C2 result.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The evaluation SHALL compute S0 = A0&B0, S1 = A1|B1, out = D[{S1,S0}].
REQ-014 The FSM SHALL have three states: IDLE, EVAL and RESP.
REQ-015 In IDLE with any req_valid set, the block SHALL pick one winner, latch its operand and index, pulse req_ready[winner] in that same cycle, and go to EVAL.
REQ-016 In IDLE with no req_valid set, the block SHALL stay in IDLE with req_ready = 0.
REQ-017 Round-robin mode SHALL search from index ptr upward modulo NREQ; ptr SHALL become winner+1 (wrapping 3->0) on response handshake.
REQ-018 Fixed-priority mode SHALL grant the lowest set index and ignore ptr.
REQ-019 EVAL SHALL last exactly one cycle, register rsp_out and rsp_id from the latched operand, and go to RESP.
REQ-020 rsp_valid SHALL be high only in RESP, giving a latency of 2 cycles from the accept cycle to the first cycle of rsp_valid.
REQ-021 In RESP, rsp_out and rsp_id SHALL hold stable until rsp_valid && rsp_ready, after which the FSM SHALL return to IDLE.
REQ-022 No request SHALL be accepted outside IDLE; req_ready SHALL be 0 in EVAL and RESP.
REQ-023 Peak throughput SHALL be one result per 3 cycles.
REQ-024 Requesters deasserting req_valid while waiting SHALL simply drop out of arbitration with no side effect.
REQ-025 If rsp_ready is already high on entry to RESP, the handshake SHALL complete in that cycle.
REQ-026 Changes on req_data of a granted requester after its accept cycle SHALL not affect the result.

Reset
REQ-027 On clr_n low, asynchronously: state = IDLE, ptr = 0, rsp_valid = 0, rsp_out = 0, rsp_id = 0, req_ready = 0, busy = 0.
REQ-028 Reset asserted mid-operation (EVAL or RESP) SHALL discard the in-flight result with no response.
REQ-029 Deassertion of clr_n SHALL take effect at the next posedge, and IDLE arbitration SHALL be possible in that cycle.

Structure
REQ-030 Package actel_pkg SHALL hold the state enum, NREQ, and the operand field offsets (A0/B0/A1/B1/D).
REQ-031 The combinational evaluator SHALL be a single sub-module c2_eval (inputs A0, B0, A1, B1, D[3:0]; output out), instantiated once.
REQ-032 The grant logic SHALL be an in-module function, with no further sub-modules.

Verification
REQ-033 Single request: req0 data 8'b0010_0011 (A0=B0=1, A1=B1=0, D=0010), rsp_ready = 1 -> req_ready = 0001 at T, rsp_valid at T+2, rsp_out = 1, rsp_id = 0.
REQ-034 All four valid continuously, RR_EN = 1, rsp_ready = 1 -> grant order 0, 1, 2, 3, 0, with accepts 3 cycles apart.
REQ-035 RR_EN = 0 with req0 and req3 always valid -> req3 is never granted and req0 is granted every 3 cycles.
REQ-036 Backpressure: rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_out and rsp_id hold stable, there are no accepts, and busy = 1.
REQ-037 clr_n pulsed low during EVAL -> no rsp_valid, all outputs 0, ptr = 0, and the next request gets a fresh grant starting from index 0.
REQ-038 Exhaustive sweep of all 256 operand values via req2 -> rsp_out matches D[{A1|B1, A0&B0}] every time.
